kbest_layer_scheduler: RTL and testbench
========================================

Name: kbest_layer_scheduler

Overview:
- Sequences one 4x4 K-best detection job through the per-layer path units: PathGenerator handles layer 3, and the PathFinder instances with N=2, 3 and 4 handle layers 2, 1 and 0.
- For each layer, in order 3, 2, 1, 0, it selects the R row and Y element, fires that layer's unit, waits the fixed datapath latency, then strobes capture of the sorted paths/PEDs into the survivor buffer.
- Jobs arrive and results leave on valid/ready handshakes. One job is in flight at a time.

Parameters:
- LAT, 2, cycles from a layer issue to its sorted PATH/PED being stable at the buffer input; legal range 1..15.
- ID_W, 4, width of the job tag.
- CNT_W, 8, width of the completed-job counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- job_valid  in  1  new job (R, Y loaded upstream) available
- job_ready  out  1  scheduler can accept a job
- job_id  in  ID_W  tag of the offered job
- abort  in  1  synchronous flush of the current job
- lay_sel  out  2  current layer index; drives the R-row and Y-element muxes
- lay_en  out  4  one-hot issue strobe; bit k fires the layer-k unit
- buf_clr  out  1  pulse that clears the survivor PATH/PED buffer
- cap_en  out  1  pulse that captures the layer output into the survivor buffer
- busy  out  1  a job is in flight (not IDLE)
- res_valid  out  1  final survivor buffer is valid
- res_ready  in  1  consumer accepts the result
- res_id  out  ID_W  tag of the result
- done_cnt  out  CNT_W  number of completed result transfers

Behaviour:
- All state updates on posedge clk. rst=0 at an edge forces every register to reset, including mid-job.
- Reset values: state=IDLE; job_ready=0 during reset; all other outputs 0.
- States and outputs:
  - IDLE: job_ready=1.
  - ISSUE: lay_en=1<<lay_sel for one cycle.
  - WAIT: wait counter runs.
  - CAP: cap_en=1 for one cycle.
  - DONE: res_valid=1.
  - busy=1 in every state except IDLE.
- IDLE -> ISSUE: on job_valid&&job_ready. At that edge, latch job_id into res_id, set lay_sel=3 and pulse buf_clr=1 for exactly the next cycle.
- ISSUE -> WAIT: load wcnt=LAT-1. If LAT==1, go directly to CAP instead.
- WAIT: decrement wcnt each cycle; go to CAP on the cycle wcnt==1. Net effect: cap_en rises exactly LAT cycles after the lay_en pulse.
- CAP:
  - If lay_sel==0, go to DONE.
  - Otherwise decrement lay_sel and return to ISSUE.
  - Per-layer period is LAT+1 cycles.
- lay_sel is held constant from ISSUE through CAP of its layer. It changes only on the CAP->ISSUE edge.
- DONE: res_valid and res_id are held until res_ready. On res_valid&&res_ready, go to IDLE, increment done_cnt (wraps 2^CNT_W-1 -> 0) and drop res_valid.
  - job_ready is 0 in DONE, so there is no same-cycle accept. The next accept is possible one cycle after the transfer.
- Timing: handshake edge at cycle a → ISSUE of layer 3 at a+1 → final cap_en at a+4+4*LAT → res_valid from a+5+4*LAT.
- abort=1 at an edge (any state other than IDLE):
  - Next state is IDLE; lay_en, cap_en and res_valid are 0 next cycle.
  - done_cnt is not incremented and any pending result is discarded.
  - abort takes priority over res_ready and over job_valid. An abort in IDLE blocks the accept that cycle.
- Outputs are registered: lay_en, cap_en, buf_clr, res_valid and job_ready all come from flops, with no combinational path from inputs.
- job_id/job_valid changes while busy are ignored.

Test Plan:
1. LAT=2; reset then job_valid=1, id=5 at cycle 0:
   - buf_clr at 1.
   - lay_en = 1000 at 1, 0100 at 4, 0010 at 7, 0001 at 10.
   - cap_en at 3, 6, 9, 12.
   - res_valid=1, res_id=5 at 13.
   - res_ready=1 at 13 → IDLE at 14 and done_cnt=1.
2. LAT=1: same job → lay_en at 1, 3, 5, 7; cap_en at 2, 4, 6, 8; res_valid at 9.
3. Hold res_ready=0 for 10 cycles in DONE → res_valid/res_id stable, job_ready=0, a new job_valid is ignored. res_ready=1 → transfer; job_ready=1 on the following cycle.
4. abort=1 while lay_sel=1 (WAIT) → next cycle IDLE, busy=0, no cap_en, done_cnt unchanged. A subsequent job runs the full sequence starting at layer 3 with buf_clr.
5. rst=0 mid-CAP, then released → all outputs 0 during reset, job_ready=1 after; abort asserted together with job_valid in IDLE → not accepted.
6. 256 back-to-back jobs with res_ready tied 1 → done_cnt wraps to 0; each result's res_id equals its job_id.

Source files
------------

// File: rtl/kbest_layer_scheduler.sv
// Layer sequencer for a 4x4 K-best detector: walks layers 3..0, firing each path
// unit, waiting out its datapath latency and strobing survivor capture.
module kbest_layer_scheduler #(
  parameter int LAT   = 2,
  parameter int ID_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [ID_W-1:0]  job_id,
  input  logic             abort,
  output logic [1:0]       lay_sel,
  output logic [3:0]       lay_en,
  output logic             buf_clr,
  output logic             cap_en,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAP, DONE} state_t;

  state_t     state;
  logic [3:0] wcnt;
  logic [1:0] nxt_sel;

  assign nxt_sel = lay_sel - 2'd1;

  // Outputs are set on the same edge that enters the state they belong to,
  // so every strobe is a flop with no input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      lay_sel   <= '0;
      lay_en    <= '0;
      buf_clr   <= 1'b0;
      cap_en    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      done_cnt  <= '0;
      job_ready <= 1'b0;
    end else begin
      lay_en  <= '0;
      buf_clr <= 1'b0;
      cap_en  <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        wcnt      <= '0;
        lay_sel   <= '0;
        busy      <= 1'b0;
        res_valid <= 1'b0;
        job_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (job_valid && job_ready && !abort) begin
              state     <= ISSUE;
              res_id    <= job_id;
              lay_sel   <= 2'd3;
              lay_en    <= 4'b1000;
              buf_clr   <= 1'b1;
              busy      <= 1'b1;
              job_ready <= 1'b0;
            end else begin
              job_ready <= 1'b1;
            end
          end
          ISSUE: begin
            if (LAT == 1) begin
              state  <= CAP;
              cap_en <= 1'b1;
            end else begin
              state <= WAIT;
              wcnt  <= 4'(LAT - 1);
            end
          end
          WAIT: begin
            wcnt <= wcnt - 4'd1;
            if (wcnt == 4'd1) begin
              state  <= CAP;
              cap_en <= 1'b1;
            end
          end
          CAP: begin
            if (lay_sel == 2'd0) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state   <= ISSUE;
              lay_sel <= nxt_sel;
              lay_en  <= 4'b0001 << nxt_sel;
            end
          end
          DONE: begin
            if (res_valid && res_ready) begin
              state     <= IDLE;
              res_valid <= 1'b0;
              busy      <= 1'b0;
              job_ready <= 1'b1;
              done_cnt  <= done_cnt + 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbest_layer_scheduler.sv
// Directed bench for kbest_layer_scheduler: LAT=2 main instance plus a LAT=1
// instance sharing the same inputs for the short-latency timing.
module tb_kbest_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst, job_valid, abort, res_ready;
  logic [3:0] job_id;

  logic       job_ready, buf_clr, cap_en, busy, res_valid;
  logic [1:0] lay_sel;
  logic [3:0] lay_en, res_id;
  logic [7:0] done_cnt;

  logic       job_ready1, buf_clr1, cap_en1, busy1, res_valid1;
  logic [1:0] lay_sel1;
  logic [3:0] lay_en1, res_id1;
  logic [7:0] done_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kbest_layer_scheduler #(.LAT(2), .ID_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_id(job_id), .abort(abort), .lay_sel(lay_sel), .lay_en(lay_en),
    .buf_clr(buf_clr), .cap_en(cap_en), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_id(res_id), .done_cnt(done_cnt)
  );

  kbest_layer_scheduler #(.LAT(1), .ID_W(4), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready1),
    .job_id(job_id), .abort(abort), .lay_sel(lay_sel1), .lay_en(lay_en1),
    .buf_clr(buf_clr1), .cap_en(cap_en1), .busy(busy1), .res_valid(res_valid1),
    .res_ready(res_ready), .res_id(res_id1), .done_cnt(done_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_lay(input int c, input int l);
    for (int k = 0; k < 4; k++)
      if (c == 1 + k * (l + 1)) return 4'(8 >> k);
    return 4'd0;
  endfunction

  function automatic logic exp_cap(input int c, input int l);
    for (int k = 0; k < 4; k++)
      if (c == (k + 1) * (l + 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 40 && !job_ready; i++) step();
    check(tag, 32'(job_ready), 32'd1);
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 60 && !res_valid; i++) step();
    check(tag, 32'(res_valid), 32'd1);
  endtask

  // Accept a job at cycle 0 and trace cycles 1..14 against the issue/capture schedule.
  task automatic run_job(input logic [3:0] id, input bit with_lat1);
    res_ready = 1'b1;
    wait_ready("run ready");
    job_valid = 1'b1;
    job_id    = id;
    step();
    job_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("lay_en c%0d", c), 32'(lay_en), 32'(exp_lay(c, 2)));
      check($sformatf("cap_en c%0d", c), 32'(cap_en), 32'(exp_cap(c, 2)));
      check($sformatf("res_valid c%0d", c), 32'(res_valid), 32'(c == 13));
      check($sformatf("buf_clr c%0d", c), 32'(buf_clr), 32'(c == 1));
      check($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 13));
      if (c <= 12)
        check($sformatf("lay_sel c%0d", c), 32'(lay_sel), 32'(3 - (c - 1) / 3));
      if (c == 13) check("res_id", 32'(res_id), 32'(id));
      if (c == 14) check("job_ready after xfer", 32'(job_ready), 32'd1);
      if (with_lat1) begin
        check($sformatf("lat1 lay_en c%0d", c), 32'(lay_en1), 32'(exp_lay(c, 1)));
        check($sformatf("lat1 cap_en c%0d", c), 32'(cap_en1), 32'(exp_cap(c, 1)));
        check($sformatf("lat1 res_valid c%0d", c), 32'(res_valid1), 32'(c == 9));
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b0; job_valid = 1'b0; abort = 1'b0; res_ready = 1'b0; job_id = 4'd0;
    step(); step(); step();
    check("rst job_ready", 32'(job_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst lay_en", 32'(lay_en), 32'd0);
    check("rst done_cnt", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    step();
    check("post-rst job_ready", 32'(job_ready), 32'd1);

    // Plan 1 and 2: full job on LAT=2 and LAT=1 together
    run_job(4'd5, 1'b1);
    check("t1 done_cnt", 32'(done_cnt), 32'd1);
    check("t2 done_cnt", 32'(done_cnt1), 32'd1);

    // Plan 3: result held under backpressure, new offers ignored
    res_ready = 1'b0;
    wait_ready("t3 ready");
    job_valid = 1'b1; job_id = 4'd9;
    step();
    job_valid = 1'b0;
    wait_result("t3 result");
    for (int i = 0; i < 10; i++) begin
      check("t3 res_valid hold", 32'(res_valid), 32'd1);
      check("t3 res_id hold", 32'(res_id), 32'd9);
      check("t3 job_ready low", 32'(job_ready), 32'd0);
      job_valid = 1'b1; job_id = 4'd3;
      step();
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    check("t3 res_id before xfer", 32'(res_id), 32'd9);
    step();
    check("t3 res_valid drop", 32'(res_valid), 32'd0);
    check("t3 job_ready", 32'(job_ready), 32'd1);
    check("t3 done_cnt", 32'(done_cnt), 32'd2);

    // Plan 4: abort in WAIT of layer 1
    wait_ready("t4 ready");
    job_valid = 1'b1; job_id = 4'd7;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 40 && !(lay_sel == 2'd1 && busy && lay_en == 4'd0 && !cap_en); i++) step();
    check("t4 reach wait", 32'(lay_sel == 2'd1 && busy && lay_en == 4'd0 && !cap_en), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4 busy", 32'(busy), 32'd0);
    check("t4 cap_en", 32'(cap_en), 32'd0);
    check("t4 res_valid", 32'(res_valid), 32'd0);
    check("t4 job_ready", 32'(job_ready), 32'd1);
    check("t4 done_cnt", 32'(done_cnt), 32'd2);
    step();
    check("t4 cap_en later", 32'(cap_en), 32'd0);
    run_job(4'd11, 1'b0);
    check("t4 done_cnt after", 32'(done_cnt), 32'd3);

    // Plan 5: reset mid-CAP, then abort blocks an IDLE accept
    wait_ready("t5 ready");
    job_valid = 1'b1; job_id = 4'd6;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 20 && !cap_en; i++) step();
    check("t5 reach cap", 32'(cap_en), 32'd1);
    rst = 1'b0;
    step();
    check("t5 rst cap_en", 32'(cap_en), 32'd0);
    check("t5 rst lay_en", 32'(lay_en), 32'd0);
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst job_ready", 32'(job_ready), 32'd0);
    check("t5 rst res_id", 32'(res_id), 32'd0);
    check("t5 rst done_cnt", 32'(done_cnt), 32'd0);
    check("t5 rst lay_sel", 32'(lay_sel), 32'd0);
    rst = 1'b1;
    step();
    check("t5 job_ready", 32'(job_ready), 32'd1);
    abort = 1'b1; job_valid = 1'b1; job_id = 4'd2;
    step();
    abort = 1'b0; job_valid = 1'b0;
    check("t5 abort busy", 32'(busy), 32'd0);
    check("t5 abort buf_clr", 32'(buf_clr), 32'd0);
    check("t5 abort lay_en", 32'(lay_en), 32'd0);
    check("t5 abort job_ready", 32'(job_ready), 32'd1);

    // Plan 6: 256 jobs, counter wraps
    res_ready = 1'b1;
    for (int j = 0; j < 256; j++) begin
      wait_ready("t6 ready");
      job_valid = 1'b1; job_id = 4'(j);
      step();
      job_valid = 1'b0;
      wait_result("t6 result");
      check($sformatf("t6 res_id j%0d", j), 32'(res_id), 32'(j % 16));
      step();
      if (j == 254) check("t6 done_cnt 255", 32'(done_cnt), 32'd255);
    end
    check("t6 done_cnt wrap", 32'(done_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
